pipelined_addsub: RTL and testbench



---
 rtl/pipelined_addsub.sv | 121 ++++++++++++
 tb/tb_pipelined_addsub.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract split into STAGES carry-chained slices, with valid/ready on both sides.
// Optional build macro ADDER_SAT_EN: clamps the result to the signed limit on overflow.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_carry,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  generate
    if (WIDTH % STAGES != 0) begin : g_bad_split
      $error("pipelined_addsub: WIDTH must be a multiple of STAGES");
    end
  endgenerate

  // Stage k registers: operands (b already inverted for subtract), partial sum, slice carry, valid.
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];
  logic             ovf_q;

  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];
  logic [WIDTH-1:0] s_src [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             c_src [STAGES];
  logic             v_src [STAGES];
  logic             c_d   [STAGES];
  logic             ovf_d;
  logic             advance;

  always_comb begin
    // NOTE: every signal gets a value on every path through this block, so no latches are inferred.
    advance  = !v_q[LAST] || out_ready;

    a_src[0] = in_a;
    b_src[0] = in_sub ? ~in_b : in_b;
    c_src[0] = in_sub ? ~in_carry : in_carry;
    s_src[0] = '0;
    v_src[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      c_src[k] = c_q[k-1];
      s_src[k] = s_q[k-1];
      v_src[k] = v_q[k-1];
    end

    // Each stage adds its own slice; lower slices ride along unchanged, upper ones are overwritten later.
    for (int k = 0; k < STAGES; k++) begin
      s_d[k] = s_src[k];
      {c_d[k], s_d[k][k*SW +: SW]} = {1'b0, a_src[k][k*SW +: SW]}
                                   + {1'b0, b_src[k][k*SW +: SW]}
                                   + (SW+1)'(c_src[k]);
    end

    ovf_d = (a_src[LAST][WIDTH-1] == b_src[LAST][WIDTH-1]) &&
            (s_d[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);

`ifdef ADDER_SAT_EN
    if (ovf_d) begin
      s_d[LAST] = a_src[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    // Wrapping result: the final slice sum is passed through unchanged.
`endif
  end

  // NOTE: all pipeline registers are cleared by reset so output fields are never X after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      // NOTE: non-blocking assignments let every stage read its predecessor's pre-edge value.
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_src[k];
        if (v_src[k]) begin
          a_q[k] <= a_src[k];
          b_q[k] <= b_src[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
      if (v_src[LAST]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = v_q[LAST];
  assign out_sum   = s_q[LAST];
  assign out_carry = c_q[LAST];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub (WIDTH=32, STAGES=4): vector table, backpressure,
// random traffic and mid-flight reset, all scored through an expected-result queue.
module tb_pipelined_addsub;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
`ifdef ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_carry;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_ovf;

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_carry  (in_carry),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
    int          stamp;
    bit          lat_chk;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic        sub;
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
  } vec_t;

  exp_t        sb[$];
  exp_t        exp_next;
  bit          lat_on;
  int          cyc;
  int          checks;
  int          errors;
  bit          hold_prev;
  logic [31:0] prev_sum;
  logic        prev_carry;
  logic        prev_ovf;
  bit          accepted;
  logic        last_in_ready;
  logic        last_out_valid;
  vec_t        vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic sub);
    exp_t        e;
    logic [32:0] r;
    logic [31:0] be;
    logic        ce;
    be      = sub ? ~b : b;
    ce      = sub ? ~c : c;
    r       = {1'b0, a} + {1'b0, be} + 33'(ce);
    e.carry = r[32];
    e.ovf   = (a[31] == be[31]) && (r[31] != a[31]);
    e.sum   = r[31:0];
    if (SAT && e.ovf) e.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    e.stamp   = 0;
    e.lat_chk = 1'b0;
    return e;
  endfunction

  // One clock cycle: called at a negedge with inputs already driven.
  task automatic tick();
    exp_t e;
    #1;
    if (hold_prev) begin
      check("hold_sum", out_sum, prev_sum);
      check("hold_carry", out_carry, prev_carry);
      check("hold_ovf", out_ovf, prev_ovf);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got sum %0h with no result pending (cycle %0d)", out_sum, cyc);
      end else begin
        e = sb.pop_front();
        check("sum", out_sum, e.sum);
        check("carry", out_carry, e.carry);
        check("ovf", out_ovf, e.ovf);
        if (e.lat_chk) check("latency", cyc - e.stamp, STAGES);
      end
    end
    hold_prev      = out_valid && !out_ready;
    prev_sum       = out_sum;
    prev_carry     = out_carry;
    prev_ovf       = out_ovf;
    last_in_ready  = in_ready;
    last_out_valid = out_valid;
    accepted       = in_valid && in_ready;
    if (accepted) begin
      e         = exp_next;
      e.stamp   = cyc;
      e.lat_chk = lat_on;
      sb.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic c, input logic sub);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_carry = c;
    in_sub   = sub;
    exp_next = model(a, b, c, sub);
  endtask

  task automatic drain(input string name);
    in_valid = 1'b0;
    for (int i = 0; i < 60 && sb.size() > 0; i++) tick();
    check(name, sb.size(), 0);
  endtask

  task automatic idle_check(input string name, input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      check(name, out_valid, 1'b0);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, 32'h0);
    sb.delete();
    hold_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int issued;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    hold_prev = 1'b0;
    lat_on    = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_carry  = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;

    vecs[0]  = '{32'h5555_5555, 32'hAAAA_AAAA, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[1]  = '{32'h5555_5555, 32'hAAAA_AAAA, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
                 SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
                 SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1};
    vecs[6]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0,
                 SAT ? 32'h8000_0000 : 32'h0000_0000, 1'b1, 1'b1};
    vecs[7]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[8]  = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0};
    vecs[9]  = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[10] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[11] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0};

    // Reset and idle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("in_reset_valid", out_valid, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_out_valid", out_valid, 1'b0);
    check("rel_out_sum", out_sum, 32'h0);
    check("rel_out_carry", out_carry, 1'b0);
    check("rel_out_ovf", out_ovf, 1'b0);
    check("rel_in_ready", in_ready, 1'b1);
    idle_check("idle_valid", 10);

    // Vector table, back to back, with exact latency checks.
    lat_on = 1'b1;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_a     = vecs[i].a;
      in_b     = vecs[i].b;
      in_carry = vecs[i].c;
      in_sub   = vecs[i].sub;
      exp_next = '{vecs[i].sum, vecs[i].carry, vecs[i].ovf, 0, 1'b0};
      tick();
      check("tbl_accept", accepted, 1'b1);
    end
    drain("tbl_drain");
    lat_on = 1'b0;

    // Backpressure: six ops i+i, consumer stalls for cycles 5..8.
    issued = 0;
    for (int t = 0; t < 40 && (issued < 6 || sb.size() > 0); t++) begin
      out_ready = !(t >= 5 && t <= 8);
      if (issued < 6) drive_op(32'(issued), 32'(issued), 1'b0, 1'b0);
      else in_valid = 1'b0;
      tick();
      if (t >= 5 && t <= 8) begin
        check("stall_in_ready", last_in_ready, 1'b0);
        check("stall_out_valid", last_out_valid, 1'b1);
      end
      if (accepted) issued++;
    end
    check("bp_issued", issued, 6);
    drain("bp_drain");
    out_ready = 1'b1;
    idle_check("bp_idle", 3);

    // Random traffic with random consumer stalls and signed corner operands.
    issued   = 0;
    in_valid = 1'b0;
    for (int t = 0; t < 600 && (issued < 40 || sb.size() > 0); t++) begin
      logic [31:0] ra, rb;
      if (!in_valid && issued < 40 && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: ra = 32'h7FFF_FFFF;
          1: ra = 32'h8000_0000;
          2: ra = 32'hFFFF_FFFF;
          default: ra = $urandom;
        endcase
        rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        drive_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      out_ready = 1'($urandom_range(0, 2) != 0);
      tick();
      if (accepted) begin
        issued++;
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    drain("rnd_drain");

    // Mid-flight reset with ops still inside the pipe.
    for (int i = 0; i < 3; i++) begin
      drive_op(32'(100 + i), 32'h1, 1'b0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    pulse_reset();
    idle_check("post_rst_a", 10);

    // Mid-flight reset while a stalled result is presented at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_op(32'h1234_0000, 32'(i), 1'b0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_b_valid", last_out_valid, 1'b1);
    pulse_reset();
    out_ready = 1'b1;
    idle_check("post_rst_b", 10);

    // Pipe still works after reset.
    lat_on = 1'b1;
    drive_op(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
    tick();
    drain("post_rst_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
